cphase_stream_stage: RTL and testbench

Streaming controlled-phase stage of the QFT datapath. It accepts one gate configuration (control qubit, target qubit, phase index k) and then exactly 2^N_QUBITS complex amplitudes in index order. Amplitudes whose index has both the control and target bits set are rotated by exp(+i·2π/2^k) through an instantiated `ccmult_pipelined` (4-cycle latency); all others are multiplied by 1.0. Results leave through a credit-protected output FIFO with back-pressure.

---
 rtl/cphase_stream_stage_pkg.sv | 49 ++++
 rtl/ccmult_pipelined.sv | 38 +++
 rtl/cphase_stream_stage_twiddle_rom.sv | 21 ++
 rtl/cphase_stream_stage.sv | 177 +++++++++++++++++
 tb/tb_cphase_stream_stage.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cphase_stream_stage_pkg.sv
// Shared definitions for the controlled-phase streaming stage.
// Holds the fixed-point format, the complex sample type, the FSM encodings
// and the twiddle table used by the ROM.
package cphase_stream_stage_pkg;

    // Fixed-point format: Q(TOTAL_WIDTH-FRAC_WIDTH).FRAC_WIDTH, signed.
    localparam int TOTAL_WIDTH = 16;
    localparam int FRAC_WIDTH  = 12;
    localparam int MULT_WIDTH  = 2 * TOTAL_WIDTH;
    localparam int FP_ONE      = 1 << FRAC_WIDTH;

    typedef struct packed {
        logic signed [TOTAL_WIDTH-1:0] re;
        logic signed [TOTAL_WIDTH-1:0] im;
    } cplx_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    function automatic cplx_t mk_cplx(input int re, input int im);
        cplx_t c;
        c.re = TOTAL_WIDTH'(re);
        c.im = TOTAL_WIDTH'(im);
        return c;
    endfunction

    function automatic logic k_legal(input logic [3:0] k, input int k_max);
        return (k != 4'd0) && (int'(k) <= k_max);
    endfunction

    // (cos, sin)(2*pi/2^k) rounded to nearest; constants assume FRAC_WIDTH = 12.
    // Index 0 and anything past the table is the identity.
    function automatic cplx_t twiddle_lut(input logic [3:0] k);
        case (k)
            4'd1:    return mk_cplx(-4096,    0);
            4'd2:    return mk_cplx(    0, 4096);
            4'd3:    return mk_cplx( 2896, 2896);
            4'd4:    return mk_cplx( 3784, 1567);
            4'd5:    return mk_cplx( 4017,  799);
            4'd6:    return mk_cplx( 4076,  401);
            4'd7:    return mk_cplx( 4091,  201);
            4'd8:    return mk_cplx( 4095,  101);
            default: return mk_cplx(FP_ONE,   0);
        endcase
    endfunction

endpackage

// File: rtl/ccmult_pipelined.sv
// Fixed-point complex multiplier, 4-cycle latency, no stall.
// Ports: clk, rst_n (async low), a_re/a_im and b_re/b_im operands,
// p_re/p_im = (a*b) >>> FRAC_WIDTH truncated to TOTAL_WIDTH.
module ccmult_pipelined
    import cphase_stream_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [TOTAL_WIDTH-1:0] a_re,
    input  logic signed [TOTAL_WIDTH-1:0] a_im,
    input  logic signed [TOTAL_WIDTH-1:0] b_re,
    input  logic signed [TOTAL_WIDTH-1:0] b_im,
    output logic signed [TOTAL_WIDTH-1:0] p_re,
    output logic signed [TOTAL_WIDTH-1:0] p_im
);
    logic signed [MULT_WIDTH-1:0] rr, ii, ri, ir;
    logic signed [MULT_WIDTH:0]   s_re, s_im, sh_re, sh_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0; ii <= '0; ri <= '0; ir <= '0;
            s_re <= '0; s_im <= '0; sh_re <= '0; sh_im <= '0;
            p_re <= '0; p_im <= '0;
        end else begin
            rr    <= MULT_WIDTH'(a_re) * MULT_WIDTH'(b_re);
            ii    <= MULT_WIDTH'(a_im) * MULT_WIDTH'(b_im);
            ri    <= MULT_WIDTH'(a_re) * MULT_WIDTH'(b_im);
            ir    <= MULT_WIDTH'(a_im) * MULT_WIDTH'(b_re);
            s_re  <= (MULT_WIDTH+1)'(rr) - (MULT_WIDTH+1)'(ii);
            s_im  <= (MULT_WIDTH+1)'(ri) + (MULT_WIDTH+1)'(ir);
            // Arithmetic shift: multiplying by FP_ONE returns the input exactly.
            sh_re <= s_re >>> FRAC_WIDTH;
            sh_im <= s_im >>> FRAC_WIDTH;
            p_re  <= TOTAL_WIDTH'(sh_re);
            p_im  <= TOTAL_WIDTH'(sh_im);
        end
    end
endmodule

// File: rtl/cphase_stream_stage_twiddle_rom.sv
// Twiddle ROM for the controlled-phase stage: K_MAX+1 entries, registered
// output. Ports: clk, rst (sync high), en (load), k (phase index), tw (value).
// k = 0 or k > K_MAX reads as the identity (FP_ONE, 0).
module cphase_twiddle_rom
    import cphase_stream_stage_pkg::*;
#(
    parameter int K_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] k,
    output cplx_t      tw
);
    always_ff @(posedge clk) begin
        if (rst)
            tw <= mk_cplx(FP_ONE, 0);
        else if (en)
            tw <= k_legal(k, K_MAX) ? twiddle_lut(k) : mk_cplx(FP_ONE, 0);
    end
endmodule

// File: rtl/cphase_stream_stage.sv
// Streaming controlled-phase stage of the QFT datapath.
// Takes one gate config (ctrl, tgt, k), then 2^N_QUBITS amplitudes in index
// order; amplitudes with both ctrl and tgt bits set are rotated by
// exp(+i*2*pi/2^k), the rest pass through a multiply by 1.0.
// Ports: cfg_* config handshake + cfg_err pulse, in_* amplitude stream,
// out_* result stream (idx/last tagged), busy (not IDLE).
module cphase_stream_stage
    import cphase_stream_stage_pkg::*;
#(
    parameter int N_QUBITS   = 4,
    parameter int K_MAX      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(N_QUBITS)-1:0]   cfg_ctrl,
    input  logic [$clog2(N_QUBITS)-1:0]   cfg_tgt,
    input  logic [3:0]                    cfg_k,
    output logic                          cfg_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [TOTAL_WIDTH-1:0] in_re,
    input  logic signed [TOTAL_WIDTH-1:0] in_im,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [TOTAL_WIDTH-1:0] out_re,
    output logic signed [TOTAL_WIDTH-1:0] out_im,
    output logic [N_QUBITS-1:0]           out_idx,
    output logic                          out_last,
    output logic                          busy
);
    localparam int IW     = N_QUBITS;
    localparam int QW     = $clog2(N_QUBITS);
    localparam int STAGES = 5;   // operand register + 4 multiplier stages
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic          last;
        logic [IW-1:0] idx;
        cplx_t         d;
    } entry_t;

    logic [1:0]    state;
    logic [QW-1:0] ctrl_q, tgt_q;
    logic [3:0]    k_q;
    logic [IW-1:0] idx_q;
    cplx_t         tw, a_q, b_q, prod;

    logic              in_fire, push, pop;
    logic [STAGES:1]   vld_pipe, last_pipe;
    logic [STAGES:1][IW-1:0] idx_pipe;
    logic [2:0]        inflight;
    logic [CW:0]       credit_used;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake outputs are masked while rst is high so nothing is
    // offered or accepted before the state has actually cleared.
    assign inflight    = 3'($countones(vld_pipe));
    assign credit_used = (CW+1)'(count) + (CW+1)'(inflight);
    assign cfg_ready   = !rst && (state == ST_IDLE);
    assign busy        = !rst && (state != ST_IDLE);
    assign in_ready    = !rst && (state == ST_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign in_fire     = in_valid && in_ready;
    assign out_valid   = !rst && (count != '0);
    assign push        = vld_pipe[STAGES];
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctrl_q  <= '0;
            tgt_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: if (cfg_valid) begin
                    ctrl_q  <= cfg_ctrl;
                    tgt_q   <= cfg_tgt;
                    k_q     <= cfg_k;
                    // Registered so the pulse lands in the LOAD cycle.
                    cfg_err <= !k_legal(cfg_k, K_MAX);
                    state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    idx_q <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: if (in_fire) begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == '1) state <= ST_DRAIN;
                end
                default: if (inflight == 3'd0 && count == '0) state <= ST_IDLE;
            endcase
        end
    end

    // The ROM's output register doubles as the twiddle register, loaded in LOAD.
    cphase_twiddle_rom #(.K_MAX(K_MAX)) u_rom (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_LOAD),
        .k   (k_q),
        .tw  (tw)
    );

    // Operand stage; data registers free-run, vld_pipe qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= mk_cplx(FP_ONE, 0);
            vld_pipe  <= '0;
            last_pipe <= '0;
            idx_pipe  <= '0;
        end else begin
            a_q       <= '{re: in_re, im: in_im};
            b_q       <= (idx_q[ctrl_q] && idx_q[tgt_q]) ? tw : mk_cplx(FP_ONE, 0);
            vld_pipe  <= {vld_pipe[STAGES-1:1], in_fire};
            last_pipe <= {last_pipe[STAGES-1:1], idx_q == '1};
            idx_pipe  <= {idx_pipe[STAGES-1:1], idx_q};
        end
    end

    ccmult_pipelined u_mult (
        .clk   (clk),
        .rst_n (~rst),
        .a_re  (a_q.re),
        .a_im  (a_q.im),
        .b_re  (b_q.re),
        .b_im  (b_q.im),
        .p_re  (prod.re),
        .p_im  (prod.im)
    );

    // Output FIFO. The credit rule keeps count + inflight <= FIFO_DEPTH,
    // so the multiplier output can always be written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{last: last_pipe[STAGES], idx: idx_pipe[STAGES], d: prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(FIFO_DEPTH)));

    // Outputs read as zero when empty; stable while stalled since rd_ptr holds.
    assign out_re   = out_valid ? mem[rd_ptr].d.re : '0;
    assign out_im   = out_valid ? mem[rd_ptr].d.im : '0;
    assign out_idx  = out_valid ? mem[rd_ptr].idx  : '0;
    assign out_last = out_valid && mem[rd_ptr].last;
endmodule

// File: tb/tb_cphase_stream_stage.sv
module tb_cphase_stream_stage;
    import cphase_stream_stage_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready, cfg_err;
    logic [1:0] cfg_ctrl = '0, cfg_tgt = '0;
    logic [3:0] cfg_k = '0;
    logic in_valid = 1'b0, in_ready;
    logic signed [TOTAL_WIDTH-1:0] in_re = '0, in_im = '0;
    logic out_valid, out_ready = 1'b1, out_last, busy;
    logic signed [TOTAL_WIDTH-1:0] out_re, out_im;
    logic [3:0] out_idx;

    typedef struct {
        int idx;
        logic signed [TOTAL_WIDTH-1:0] re;
        logic signed [TOTAL_WIDTH-1:0] im;
        logic last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0, cyc = 0;
    int n_acc, n_out, first_acc_cyc, first_out_cyc, run_len, max_run, err_pulses, busy_cycles;
    logic signed [TOTAL_WIDTH-1:0] amp_re [N];
    logic signed [TOTAL_WIDTH-1:0] amp_im [N];

    cphase_stream_stage dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ctrl(cfg_ctrl), .cfg_tgt(cfg_tgt), .cfg_k(cfg_k), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: pops on every output handshake.
    always @(negedge clk) begin
        if (cfg_err) err_pulses++;
        if (busy) busy_cycles++;
        if (out_valid) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (!rst && out_valid && out_ready) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            checks++;
            n_out++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got idx=%0d re=%0d im=%0d, none expected",
                         out_idx, out_re, out_im);
            end else begin
                mon_e = sb.pop_front();
                if (out_idx !== 4'(mon_e.idx) || out_re !== mon_e.re ||
                    out_im !== mon_e.im || out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL sb_data got idx=%0d re=%0d im=%0d last=%b, want idx=%0d re=%0d im=%0d last=%b",
                             out_idx, out_re, out_im, out_last,
                             mon_e.idx, mon_e.re, mon_e.im, mon_e.last);
                end
            end
        end
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference twiddle from real trig; illegal k gives the identity.
    task automatic bench_tw(input int k, output int tr, output int ti);
        real a;
        if (k < 1 || k > 8) begin
            tr = FP_ONE; ti = 0;
        end else begin
            a  = 2.0 * 3.14159265358979 / real'(1 << k);
            tr = rnd(real'(FP_ONE) * $cos(a));
            ti = rnd(real'(FP_ONE) * $sin(a));
        end
    endtask

    task automatic clear_stats();
        n_acc = 0; n_out = 0; first_acc_cyc = -1; first_out_cyc = -1;
        max_run = 0; run_len = 0; err_pulses = 0; busy_cycles = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            amp_re[i] = TOTAL_WIDTH'(int'($urandom_range(16000)) - 8000);
            amp_im[i] = TOTAL_WIDTH'(int'($urandom_range(16000)) - 8000);
        end
    endtask

    // Stimulus driver: offers config, then n amplitudes; pushes expectations.
    task automatic drive_job(input int c, input int t, input int k, input int n);
        int tr, ti, br, bi;
        exp_t e;
        bit ok;
        bench_tw(k, tr, ti);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_ctrl = 2'(c); cfg_tgt = 2'(t); cfg_k = 4'(k);
        ok = 0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            ok = cfg_ready;
        end
        if (!ok) begin
            errors++;
            $display("FAIL cfg_timeout got cfg_ready=0, want 1 within 100 cycles");
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_re = amp_re[i]; in_im = amp_im[i];
            ok = 0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = in_ready;
            end
            if (!ok) begin
                errors++;
                $display("FAIL in_timeout got in_ready=0 at amp %0d, want 1 within 200 cycles", i);
                in_valid = 1'b0;
                return;
            end
            if (((i >> c) & 1) == 1 && ((i >> t) & 1) == 1) begin br = tr; bi = ti; end
            else begin br = FP_ONE; bi = 0; end
            e.idx  = i;
            e.re   = TOTAL_WIDTH'((longint'(amp_re[i]) * br - longint'(amp_im[i]) * bi) >>> FRAC_WIDTH);
            e.im   = TOTAL_WIDTH'((longint'(amp_re[i]) * bi + longint'(amp_im[i]) * br) >>> FRAC_WIDTH);
            e.last = (i == N - 1);
            sb.push_back(e);
            if (n_acc == 0) first_acc_cyc = cyc;
            n_acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int w = 0; w < 400 && !ok; w++) begin
            @(negedge clk);
            ok = !busy;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout got busy=1, want 0 within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, out_valid, busy, cfg_err, out_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got {cfg_ready,in_ready,out_valid,busy,cfg_err,last}=%b, want 000000",
                     {cfg_ready, in_ready, out_valid, busy, cfg_err, out_last});
        end
        checks++;
        if (out_re !== '0 || out_im !== '0 || out_idx !== '0) begin
            errors++;
            $display("FAIL reset_data got re=%0d im=%0d idx=%0d, want 0 0 0", out_re, out_im, out_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got cfg_ready=%b busy=%b, want 1 0", cfg_ready, busy);
        end
    endtask

    task automatic check_job_done(input string name, input int want_err);
        checks++;
        if (n_out != N || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_count got %0d outputs (%0d left), want %0d (0 left)", name, n_out, sb.size(), N);
        end
        checks++;
        if (err_pulses != want_err) begin
            errors++;
            $display("FAIL %s_cfg_err got %0d pulses, want %0d", name, err_pulses, want_err);
        end
    endtask

    task automatic test_k2_half();
        for (int i = 0; i < N; i++) begin amp_re[i] = 16'sd2048; amp_im[i] = '0; end
        clear_stats();
        drive_job(0, 1, 2, N);
        wait_idle();
        check_job_done("k2_half", 0);
    endtask

    task automatic test_k1_negate();
        fill_random();
        amp_re[3] = 16'sd100; amp_im[3] = -16'sd37;
        clear_stats();
        drive_job(0, 1, 1, N);
        wait_idle();
        check_job_done("k1_negate", 0);
    endtask

    task automatic test_illegal_k();
        fill_random();
        clear_stats();
        drive_job(1, 2, 0, N);
        wait_idle();
        check_job_done("k0_identity", 1);
        fill_random();
        clear_stats();
        drive_job(3, 0, 9, N);
        wait_idle();
        check_job_done("k9_identity", 1);
    endtask

    task automatic test_backpressure();
        fill_random();
        clear_stats();
        out_ready = 1'b0;
        fork
            drive_job(2, 3, 4, N);
            begin
                repeat (24) @(negedge clk);
                checks++;
                if (n_acc != 8 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_credit got accepted=%0d in_ready=%b, want 8 0", n_acc, in_ready);
                end
                checks++;
                if (n_out != 0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall got popped=%0d out_valid=%b, want 0 1", n_out, out_valid);
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        check_job_done("backpressure", 0);
    endtask

    task automatic test_back_to_back();
        fill_random();
        out_ready = 1'b1;
        @(negedge clk);
        clear_stats();
        drive_job(3, 1, 5, N);
        wait_idle();
        check_job_done("throughput", 0);
        checks++;
        if (first_out_cyc - first_acc_cyc != 6) begin
            errors++;
            $display("FAIL first_latency got %0d cycles, want 6", first_out_cyc - first_acc_cyc);
        end
        checks++;
        if (max_run != N) begin
            errors++;
            $display("FAIL out_run got %0d consecutive out_valid, want %0d", max_run, N);
        end
        checks++;
        if (busy_cycles != 2 + N + 6) begin
            errors++;
            $display("FAIL busy_len got %0d cycles, want %0d", busy_cycles, 2 + N + 6);
        end
    endtask

    task automatic test_reset_midjob();
        fill_random();
        clear_stats();
        drive_job(0, 2, 3, 5);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midjob_reset got out_valid=%b busy=%b cfg_ready=%b, want 0 0 1",
                     out_valid, busy, cfg_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (n_out != 0) begin
            errors++;
            $display("FAIL midjob_flush got %0d outputs after reset, want 0", n_out);
        end
        fill_random();
        clear_stats();
        drive_job(2, 2, 3, N);
        wait_idle();
        check_job_done("fresh_job", 0);
    endtask

    initial begin
        test_reset();
        test_k2_half();
        test_k1_negate();
        test_illegal_k();
        test_backpressure();
        test_back_to_back();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
